// File: rtl/viterbi_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl_if
// Bundles every non-clock/reset signal of the Viterbi frame sequencer.
//
// Signal groups:
//   symbol input   : sym_in[1:0], sym_valid, sym_ready
//   datapath feed  : bm_sym[1:0], bm_valid, refresh
//   datapath result: res_valid, res_metric_xx[3:0], res_path_xx[7:0]
//   decoded output : out_data[7:0], out_valid, out_ready (+ out_metric[3:0]
//                    when VITERBI_CTRL_METRIC_OUT_EN is defined)
//   status         : busy, timeout_err
//
// Modports:
//   master : controller view (drives sym_ready, bm_*, refresh, out_*, status)
//   slave  : surrounding system view (source, datapath, sink)
// -----------------------------------------------------------------------------
interface viterbi_frame_ctrl_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;

    logic [1:0] bm_sym;
    logic       bm_valid;
    logic       refresh;

    logic       res_valid;
    logic [3:0] res_metric_00;
    logic [3:0] res_metric_01;
    logic [3:0] res_metric_10;
    logic [3:0] res_metric_11;
    logic [7:0] res_path_00;
    logic [7:0] res_path_01;
    logic [7:0] res_path_10;
    logic [7:0] res_path_11;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic       busy;
    logic       timeout_err;

`ifdef VITERBI_CTRL_METRIC_OUT_EN
    logic [3:0] out_metric;
`endif

    modport master (
`ifdef VITERBI_CTRL_METRIC_OUT_EN
        output out_metric,
`endif
        input  sym_in, sym_valid,
        output sym_ready,
        output bm_sym, bm_valid, refresh,
        input  res_valid,
        input  res_metric_00, res_metric_01, res_metric_10, res_metric_11,
        input  res_path_00, res_path_01, res_path_10, res_path_11,
        output out_data, out_valid,
        input  out_ready,
        output busy, timeout_err
    );

    modport slave (
`ifdef VITERBI_CTRL_METRIC_OUT_EN
        input  out_metric,
`endif
        output sym_in, sym_valid,
        input  sym_ready,
        input  bm_sym, bm_valid, refresh,
        output res_valid,
        output res_metric_00, res_metric_01, res_metric_10, res_metric_11,
        output res_path_00, res_path_01, res_path_10, res_path_11,
        input  out_data, out_valid,
        output out_ready,
        input  busy, timeout_err
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl
// Frame-level sequencer for the Viterbi add-compare-select pipeline. Accepts
// FRAME_LEN 2-bit code symbols, forwards each one (registered) to the
// branch-metric unit, waits for the last stage's result, picks the survivor
// with the smallest metric, hands the decoded byte downstream and then pulses
// refresh to clear the pipeline for the next frame.
//
// Parameters:
//   FRAME_LEN : symbols per frame (2..15)
//   TIMEOUT   : cycles allowed in WAIT before the frame is aborted (1..255)
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : viterbi_frame_ctrl_if.master (symbol, datapath, output, status)
//
// Optional feature macro:
//   VITERBI_CTRL_METRIC_OUT_EN : adds bus.out_metric, the selected minimum
//                                metric, registered alongside out_data.
// -----------------------------------------------------------------------------
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_frame_ctrl_if.master bus
);

    localparam logic [3:0] FRAME_LEN_C  = 4'(FRAME_LEN);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_HOLD,
        ST_FLUSH
    } state_t;

    state_t     state_q,    state_d;
    logic [3:0] sym_cnt_q,  sym_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] bm_sym_q,   bm_sym_d;
    logic       bm_valid_q, bm_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] sel_metric;
    logic [7:0] sel_path;
    logic [3:0] sym_cnt_inc;
    logic       sym_ready;
    logic       handshake;
    logic       refresh;
    logic       timeout_err;
`ifdef VITERBI_CTRL_METRIC_OUT_EN
    logic [3:0] out_metric_q, out_metric_d;
`endif

    // Minimum-metric survivor. Strict '<' keeps the earlier index on a tie,
    // giving the 00 > 01 > 10 > 11 preference the datapath's '<=' uses.
    always_comb begin
        sel_metric = bus.res_metric_00;
        sel_path   = bus.res_path_00;
        if (bus.res_metric_01 < sel_metric) begin
            sel_metric = bus.res_metric_01;
            sel_path   = bus.res_path_01;
        end
        if (bus.res_metric_10 < sel_metric) begin
            sel_metric = bus.res_metric_10;
            sel_path   = bus.res_path_10;
        end
        if (bus.res_metric_11 < sel_metric) begin
            sel_metric = bus.res_metric_11;
            sel_path   = bus.res_path_11;
        end
    end

    // sym_ready is forced low during reset so no symbol is ever lost to it.
    assign sym_ready   = !rst && (state_q == ST_IDLE || state_q == ST_FEED);
    assign handshake   = bus.sym_valid && sym_ready;
    assign sym_cnt_inc = sym_cnt_q + 4'd1;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that skipped an assignment would infer a latch.
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        bm_sym_d     = bm_sym_q;
        bm_valid_d   = 1'b0;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        refresh      = 1'b0;
        timeout_err  = 1'b0;
`ifdef VITERBI_CTRL_METRIC_OUT_EN
        out_metric_d = out_metric_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    bm_sym_d   = bus.sym_in;
                    bm_valid_d = 1'b1;
                    sym_cnt_d  = 4'd1;
                    state_d    = ST_FEED;
                end
            end

            ST_FEED: begin
                // No handshake is a bubble: state held, bm_valid stays 0.
                if (handshake) begin
                    bm_sym_d   = bus.sym_in;
                    bm_valid_d = 1'b1;
                    sym_cnt_d  = sym_cnt_inc;
                    if (sym_cnt_inc == FRAME_LEN_C) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                // A result arriving in the last allowed cycle still wins.
                if (bus.res_valid) begin
                    out_data_d   = sel_path;
                    out_valid_d  = 1'b1;
`ifdef VITERBI_CTRL_METRIC_OUT_EN
                    out_metric_d = sel_metric;
`endif
                    state_d      = ST_HOLD;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    timeout_err = 1'b1;
                    state_d     = ST_FLUSH;
                end
            end

            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                refresh    = 1'b1;
                sym_cnt_d  = 4'd0;
                wait_cnt_d = 8'd0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= 4'd0;
            wait_cnt_q   <= 8'd0;
            bm_sym_q     <= 2'd0;
            bm_valid_q   <= 1'b0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
`ifdef VITERBI_CTRL_METRIC_OUT_EN
            out_metric_q <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            bm_sym_q     <= bm_sym_d;
            bm_valid_q   <= bm_valid_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
`ifdef VITERBI_CTRL_METRIC_OUT_EN
            out_metric_q <= out_metric_d;
`endif
        end
    end

    assign bus.sym_ready   = sym_ready;
    assign bus.bm_sym      = bm_sym_q;
    assign bus.bm_valid    = bm_valid_q;
    assign bus.refresh     = refresh;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_err;
`ifdef VITERBI_CTRL_METRIC_OUT_EN
    assign bus.out_metric  = out_metric_q;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viterbi_frame_ctrl
// Directed testbench for viterbi_frame_ctrl (FRAME_LEN=8, TIMEOUT=32).
// Inputs change just after the falling edge; outputs are read at the falling
// edge (registered) or 1 ns after an input change (combinational).
// -----------------------------------------------------------------------------
module tb_viterbi_frame_ctrl;

    localparam int FRAME_LEN = 8;
    localparam int TIMEOUT   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    viterbi_frame_ctrl_if bus ();

    viterbi_frame_ctrl #(
        .FRAME_LEN(FRAME_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.sym_in    = 2'd0;
        bus.sym_valid = 1'b0;
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.res_metric_00 = 4'd0; bus.res_metric_01 = 4'd0;
        bus.res_metric_10 = 4'd0; bus.res_metric_11 = 4'd0;
        bus.res_path_00   = 8'd0; bus.res_path_01   = 8'd0;
        bus.res_path_10   = 8'd0; bus.res_path_11   = 8'd0;
    endtask

    task automatic set_results(input logic [3:0] m0, input logic [3:0] m1,
                               input logic [3:0] m2, input logic [3:0] m3,
                               input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] p3);
        bus.res_metric_00 = m0; bus.res_metric_01 = m1;
        bus.res_metric_10 = m2; bus.res_metric_11 = m3;
        bus.res_path_00   = p0; bus.res_path_01   = p1;
        bus.res_path_10   = p2; bus.res_path_11   = p3;
    endtask

    // Feeds one full frame of back-to-back symbols; returns in WAIT cycle 1.
    task automatic feed_frame(input logic [1:0] base);
        for (int i = 0; i < FRAME_LEN; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_in    = base + 2'(i);
            tick();
        end
        bus.sym_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sym_ready: got %b expected 0", bus.sym_ready);
        end
        n_tests++;
        if ({bus.bm_sym, bus.bm_valid, bus.refresh, bus.out_data, bus.out_valid,
             bus.busy, bus.timeout_err} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bm_sym=%h bm_valid=%b refresh=%b out_data=%h out_valid=%b busy=%b timeout_err=%b expected all 0",
                     bus.bm_sym, bus.bm_valid, bus.refresh, bus.out_data,
                     bus.out_valid, bus.busy, bus.timeout_err);
        end
`ifdef VITERBI_CTRL_METRIC_OUT_EN
        n_tests++;
        if (bus.out_metric !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_out_metric: got %h expected 0", bus.out_metric);
        end
`endif
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.sym_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got sym_ready=%b busy=%b expected 1/0",
                     bus.sym_ready, bus.busy);
        end
    endtask

    task automatic test_feed_continuous();
        bus.sym_in = 2'b00;
        for (int i = 0; i < FRAME_LEN; i++) begin
            bus.sym_valid = 1'b1;
            #1;
            n_tests++;
            if (bus.sym_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL feed_ready[%0d]: got %b expected 1", i, bus.sym_ready);
            end
            tick();
            n_tests++;
            if (bus.bm_valid !== 1'b1 || bus.bm_sym !== 2'b00) begin
                n_fail++;
                $display("FAIL feed_bm[%0d]: got valid=%b sym=%b expected 1/00",
                         i, bus.bm_valid, bus.bm_sym);
            end
        end
        bus.sym_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.sym_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL feed_done_ready: got sym_ready=%b busy=%b expected 0/1",
                     bus.sym_ready, bus.busy);
        end
        tick();
        n_tests++;
        if (bus.bm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL feed_bm_ninth: got %b expected 0", bus.bm_valid);
        end
    endtask

    // Continues from WAIT left by test_feed_continuous.
    task automatic test_select_tie();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.out_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_idle[%0d]: got out_valid=%b timeout_err=%b expected 0/0",
                         i, bus.out_valid, bus.timeout_err);
            end
        end
        set_results(4'd5, 4'd2, 4'd7, 4'd2, 8'h11, 8'hA5, 8'h77, 8'h3C);
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL tie_select: got valid=%b data=%h expected 1/a5",
                     bus.out_valid, bus.out_data);
        end
`ifdef VITERBI_CTRL_METRIC_OUT_EN
        n_tests++;
        if (bus.out_metric !== 4'd2) begin
            n_fail++;
            $display("FAIL tie_metric: got %h expected 2", bus.out_metric);
        end
`endif
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.refresh !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got valid=%b data=%h refresh=%b expected 1/a5/0",
                         k, bus.out_valid, bus.out_data, bus.refresh);
            end
            // A stray result outside WAIT must not disturb the held byte.
            if (k == 1) begin
                set_results(4'd0, 4'd9, 4'd9, 4'd9, 8'hFF, 8'h00, 8'h00, 8'h00);
                bus.res_valid = 1'b1;
            end
            tick();
            bus.res_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.refresh !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_xfer: got valid=%b refresh=%b expected 1/0",
                     bus.out_valid, bus.refresh);
        end
        tick();
        bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.refresh !== 1'b1 || bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got refresh=%b valid=%b sym_ready=%b expected 1/0/0",
                     bus.refresh, bus.out_valid, bus.sym_ready);
        end
        tick();
        n_tests++;
        if (bus.refresh !== 1'b0 || bus.busy !== 1'b0 || bus.sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_flush: got refresh=%b busy=%b sym_ready=%b expected 0/0/1",
                     bus.refresh, bus.busy, bus.sym_ready);
        end
    endtask

    task automatic test_bubbles();
        logic [1:0] syms [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10};
        int hs = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            if (i % 2 == 0) begin
                bus.sym_valid = 1'b1;
                bus.sym_in    = syms[hs];
            end else begin
                bus.sym_valid = 1'b0;
                bus.sym_in    = 2'b11;
            end
            if (i == 2 * FRAME_LEN - 2) begin
                #1;
                n_tests++;
                if (bus.sym_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bubble_last_ready: got %b expected 1", bus.sym_ready);
                end
            end
            tick();
            n_tests++;
            if (i % 2 == 0) begin
                if (bus.bm_valid !== 1'b1 || bus.bm_sym !== syms[hs]) begin
                    n_fail++;
                    $display("FAIL bubble_bm[%0d]: got valid=%b sym=%b expected 1/%b",
                             i, bus.bm_valid, bus.bm_sym, syms[hs]);
                end
                hs++;
            end else if (bus.bm_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bubble_gap[%0d]: got valid=%b expected 0", i, bus.bm_valid);
            end
        end
        #1;
        n_tests++;
        if (bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_end_ready: got %b expected 0", bus.sym_ready);
        end
        set_results(4'd3, 4'd3, 4'd1, 4'd9, 8'h12, 8'h34, 8'h5A, 8'h78);
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL bubble_result: got valid=%b data=%h expected 1/5a",
                     bus.out_valid, bus.out_data);
        end
`ifdef VITERBI_CTRL_METRIC_OUT_EN
        n_tests++;
        if (bus.out_metric !== 4'd1) begin
            n_fail++;
            $display("FAIL bubble_metric: got %h expected 1", bus.out_metric);
        end
`endif
        // out_ready already high: transfer completes in the first valid cycle.
        tick();
        n_tests++;
        if (bus.refresh !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ready_flush: got refresh=%b valid=%b expected 1/0",
                     bus.refresh, bus.out_valid);
        end
        bus.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int first_to  = -1;
        int to_pulses = 0;
        int ref_cycle = -1;
        int ref_count = 0;
        bit saw_valid = 1'b0;
        feed_frame(2'b01);
        for (int c = 1; c <= TIMEOUT + 8; c++) begin
            if (bus.timeout_err === 1'b1) begin
                to_pulses++;
                if (first_to < 0) first_to = c;
            end
            if (bus.refresh === 1'b1) begin
                ref_count++;
                if (ref_cycle < 0) ref_cycle = c;
            end
            if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
            tick();
        end
        n_tests++;
        if (first_to != TIMEOUT || to_pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_pulse: got first=%0d count=%0d expected %0d/1",
                     first_to, to_pulses, TIMEOUT);
        end
        n_tests++;
        if (ref_cycle != TIMEOUT + 1 || ref_count != 1) begin
            n_fail++;
            $display("FAIL timeout_refresh: got cycle=%0d count=%0d expected %0d/1",
                     ref_cycle, ref_count, TIMEOUT + 1);
        end
        n_tests++;
        if (saw_valid) begin
            n_fail++;
            $display("FAIL timeout_no_output: got out_valid asserted expected never");
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_in    = 2'b10;
            tick();
        end
        bus.sym_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b expected 0", bus.sym_ready);
        end
        tick();
        n_tests++;
        if ({bus.bm_sym, bus.bm_valid, bus.refresh, bus.out_data, bus.out_valid,
             bus.busy, bus.timeout_err} !== 15'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got bm_sym=%h bm_valid=%b refresh=%b busy=%b expected all 0",
                     bus.bm_sym, bus.bm_valid, bus.refresh, bus.busy);
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_in    = 2'(i);
            tick();
        end
        bus.sym_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.sym_ready !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_needs_full: got sym_ready=%b busy=%b expected 1/1",
                     bus.sym_ready, bus.busy);
        end
        bus.sym_valid = 1'b1;
        tick();
        bus.sym_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_frame_end: got sym_ready=%b expected 0", bus.sym_ready);
        end
        set_results(4'd4, 4'd4, 4'd4, 4'd4, 8'hC3, 8'h01, 8'h02, 8'h03);
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL all_tie: got valid=%b data=%h expected 1/c3",
                     bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] m [2][4] = '{'{4'd9, 4'd8, 4'd7, 4'd0}, '{4'd15, 4'd15, 4'd14, 4'd15}};
        logic [7:0] p [2][4] = '{'{8'h01, 8'h02, 8'h03, 8'hF0}, '{8'h0A, 8'h0B, 8'h6C, 8'h0D}};
        logic [7:0] exp_data [2] = '{8'hF0, 8'h6C};
        logic [3:0] exp_metric [2] = '{4'd0, 4'd14};
        // Result strobe while IDLE is ignored.
        set_results(4'd0, 4'd1, 4'd1, 4'd1, 8'hEE, 8'h00, 8'h00, 8'h00);
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_res_ignored: got valid=%b busy=%b expected 0/0",
                     bus.out_valid, bus.busy);
        end
        for (int f = 0; f < 2; f++) begin
            #1;
            n_tests++;
            if (bus.sym_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", f, bus.sym_ready);
            end
            feed_frame(2'(f));
            set_results(m[f][0], m[f][1], m[f][2], m[f][3], p[f][0], p[f][1], p[f][2], p[f][3]);
            bus.res_valid = 1'b1;
            tick();
            bus.res_valid = 1'b0;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data[f]) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got valid=%b data=%h expected 1/%h",
                         f, bus.out_valid, bus.out_data, exp_data[f]);
            end
`ifdef VITERBI_CTRL_METRIC_OUT_EN
            n_tests++;
            if (bus.out_metric !== exp_metric[f]) begin
                n_fail++;
                $display("FAIL b2b_metric[%0d]: got %h expected %h",
                         f, bus.out_metric, exp_metric[f]);
            end
`else
            if (exp_metric[f] > 4'd15) $display("unreachable");
`endif
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_feed_continuous();
        test_select_tie();
        test_hold();
        test_bubbles();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
